sad_best_select: RTL and testbench

- Downstream consumer of the 12-way SAD tree.
- Takes the 12 lambda-weighted SAD results each time the tree presents them, and finds the minimum with a 3-stage pipelined comparator tree.
- Keeps a running best across NUM_ROUNDS presentations (e.g. half-pel then quarter-pel refinement of one block), then reports the winning candidate index, its cost and the round it came from.
- Feeds the motion-vector update / next-refinement-centre logic.

---
 rtl/sad_best_select.sv | 229 ++++++++++++++++++++++
 tb/tb_sad_best_select.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sad_best_select.sv
// sad_best_select: finds the minimum of twelve lambda-weighted SAD costs with a
// three-stage comparator tree and keeps a running best across NUM_ROUNDS
// presentations. It reports the winning index, cost and round, then pulses done.

// Two-input minimum. Input a always carries the lower candidate index, so b
// wins only on strictly smaller cost. This makes equal costs go to the lower index.
module sad_min2 #(
    parameter int SW = 17
) (
    input  logic [SW-1:0] a_cost_i,
    input  logic [3:0]    a_idx_i,
    input  logic [SW-1:0] b_cost_i,
    input  logic [3:0]    b_idx_i,
    output logic [SW-1:0] y_cost_o,
    output logic [3:0]    y_idx_o
);
    logic sel_b;

    // Pick b only when it is strictly cheaper.
    always_comb begin
        sel_b    = (b_cost_i < a_cost_i);
        y_cost_o = sel_b ? b_cost_i : a_cost_i;
        y_idx_o  = sel_b ? b_idx_i  : a_idx_i;
    end
endmodule

module sad_best_select #(
    parameter int DATAWIDTH  = 8,
    parameter int NUM_ROUNDS = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   sad_valid,
    input  logic                   left_only,
    input  logic [DATAWIDTH+8:0]   sad_0,
    input  logic [DATAWIDTH+8:0]   sad_1,
    input  logic [DATAWIDTH+8:0]   sad_2,
    input  logic [DATAWIDTH+8:0]   sad_3,
    input  logic [DATAWIDTH+8:0]   sad_4,
    input  logic [DATAWIDTH+8:0]   sad_5,
    input  logic [DATAWIDTH+8:0]   sad_6,
    input  logic [DATAWIDTH+8:0]   sad_7,
    input  logic [DATAWIDTH+8:0]   sad_8,
    input  logic [DATAWIDTH+8:0]   sad_9,
    input  logic [DATAWIDTH+8:0]   sad_10,
    input  logic [DATAWIDTH+8:0]   sad_11,
    output logic [DATAWIDTH+8:0]   best_sad,
    output logic [3:0]             best_idx,
    output logic [3:0]             best_round,
    output logic                   busy,
    output logic                   done
);
    localparam int             SW       = DATAWIDTH + 9;
    localparam logic [SW-1:0]  COST_MAX = '1;
    localparam logic [3:0]     NR       = 4'(NUM_ROUNDS);
    localparam logic [3:0]     LAST     = 4'(NUM_ROUNDS - 1);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t state_q, state_d;

    // Candidate inputs, with the right-hand (PVSO-only) half masked when left_only
    logic [11:0][SW-1:0] sad_in;
    logic [11:0][SW-1:0] s0_cost;

    // Stage registers: value, index, round tag; valids live in vld_pipe_q
    logic [5:0][SW-1:0]  s1_cost_d, s1_cost_q;
    logic [5:0][3:0]     s1_idx_d,  s1_idx_q;
    logic [2:0][SW-1:0]  s2_cost_d, s2_cost_q;
    logic [2:0][3:0]     s2_idx_d,  s2_idx_q;
    logic [SW-1:0]       s3a_cost;
    logic [3:0]          s3a_idx;
    logic [SW-1:0]       s3_cost_d, s3_cost_q;
    logic [3:0]          s3_idx_d,  s3_idx_q;
    logic [3:0]          tag0, tag1_q, tag2_q, tag3_q;
    logic [2:0]          vld_pipe_d, vld_pipe_q;

    // Running best and search bookkeeping
    logic [SW-1:0]       best_sad_d, best_sad_q;
    logic [3:0]          best_idx_d, best_idx_q;
    logic [3:0]          best_round_d, best_round_q;
    logic [3:0]          cnt_d, cnt_q;
    logic                done_d, done_q;
    logic                accept;

    assign sad_in = {sad_11, sad_10, sad_9, sad_8, sad_7, sad_6,
                     sad_5,  sad_4,  sad_3, sad_2, sad_1, sad_0};

    // A start opens a fresh search, so the sample that arrives with it is always taken.
    always_comb begin
        accept = sad_valid && (start || (state_q == S_RUN && cnt_q < NR));
        tag0   = start ? 4'd0 : cnt_q;
    end

    genvar g;
    generate
        for (g = 0; g < 12; g++) begin : g_mask
            if (g >= 6) begin : g_right
                assign s0_cost[g] = left_only ? COST_MAX : sad_in[g];
            end else begin : g_left
                assign s0_cost[g] = sad_in[g];
            end
        end

        for (g = 0; g < 6; g++) begin : g_s1
            sad_min2 #(.SW(SW)) u_min (
                .a_cost_i (s0_cost[2*g]),
                .a_idx_i  (4'(2*g)),
                .b_cost_i (s0_cost[2*g+1]),
                .b_idx_i  (4'(2*g+1)),
                .y_cost_o (s1_cost_d[g]),
                .y_idx_o  (s1_idx_d[g])
            );
        end

        for (g = 0; g < 3; g++) begin : g_s2
            sad_min2 #(.SW(SW)) u_min (
                .a_cost_i (s1_cost_q[2*g]),
                .a_idx_i  (s1_idx_q[2*g]),
                .b_cost_i (s1_cost_q[2*g+1]),
                .b_idx_i  (s1_idx_q[2*g+1]),
                .y_cost_o (s2_cost_d[g]),
                .y_idx_o  (s2_idx_d[g])
            );
        end
    endgenerate

    // Three-way minimum as two chained compares, still lowest index first.
    sad_min2 #(.SW(SW)) u_s3a (
        .a_cost_i (s2_cost_q[0]),
        .a_idx_i  (s2_idx_q[0]),
        .b_cost_i (s2_cost_q[1]),
        .b_idx_i  (s2_idx_q[1]),
        .y_cost_o (s3a_cost),
        .y_idx_o  (s3a_idx)
    );

    sad_min2 #(.SW(SW)) u_s3b (
        .a_cost_i (s3a_cost),
        .a_idx_i  (s3a_idx),
        .b_cost_i (s2_cost_q[2]),
        .b_idx_i  (s2_idx_q[2]),
        .y_cost_o (s3_cost_d),
        .y_idx_o  (s3_idx_d)
    );

    // Stage data is qualified by vld_pipe_q and needs no reset.
    always_ff @(posedge clock) begin
        s1_cost_q <= s1_cost_d;
        s1_idx_q  <= s1_idx_d;
        s2_cost_q <= s2_cost_d;
        s2_idx_q  <= s2_idx_d;
        s3_cost_q <= s3_cost_d;
        s3_idx_q  <= s3_idx_d;
        tag1_q    <= tag0;
        tag2_q    <= tag1_q;
        tag3_q    <= tag2_q;
    end

    // Valid shift register. start kills everything beyond S1 so an aborted search never lands.
    always_comb begin
        vld_pipe_d[0] = accept;
        vld_pipe_d[1] = vld_pipe_q[0] && !start;
        vld_pipe_d[2] = vld_pipe_q[1] && !start;
    end

    // Valid bits register.
    always_ff @(posedge clock) begin
        if (reset) vld_pipe_q <= '0;
        else       vld_pipe_q <= vld_pipe_d;
    end

    // Search FSM, round counter and running-best update. start takes precedence over a landing sample.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        best_sad_d   = best_sad_q;
        best_idx_d   = best_idx_q;
        best_round_d = best_round_q;
        done_d       = 1'b0;
        if (start) begin
            state_d      = S_RUN;
            cnt_d        = accept ? 4'd1 : 4'd0;
            best_sad_d   = COST_MAX;
            best_idx_d   = 4'd0;
            best_round_d = 4'd0;
        end else begin
            if (accept) cnt_d = cnt_q + 4'd1;
            if (state_q == S_RUN && vld_pipe_q[2]) begin
                // Strictly-less keeps the earlier round on cross-round ties.
                if (s3_cost_q < best_sad_q) begin
                    best_sad_d   = s3_cost_q;
                    best_idx_d   = s3_idx_q;
                    best_round_d = tag3_q;
                end
                if (tag3_q == LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    // State and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            best_sad_q   <= COST_MAX;
            best_idx_q   <= 4'd0;
            best_round_q <= 4'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            best_sad_q   <= best_sad_d;
            best_idx_q   <= best_idx_d;
            best_round_q <= best_round_d;
            done_q       <= done_d;
        end
    end

    assign best_sad   = best_sad_q;
    assign best_idx   = best_idx_q;
    assign best_round = best_round_q;
    assign busy       = (state_q == S_RUN);
    assign done       = done_q;
endmodule

// File: tb/tb_sad_best_select.sv
// Bench for sad_best_select: table of two-round searches with hand-derived
// expected results, a due-cycle scoreboard, and hand sequences for abort and
// reset corner cases.
module tb_sad_best_select;
    localparam int SW = 17;
    localparam int CMAX = 131071;

    logic clock = 1'b0;
    logic reset, start, sad_valid, left_only;
    logic [SW-1:0] sad [12];
    logic [SW-1:0] best_sad;
    logic [3:0]    best_idx, best_round;
    logic          busy, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    typedef struct {
        bit lo; int base; int step; int k1; int v1; int k2; int v2;
        int esad; int eidx; int ernd; bit edn;
    } vec_t;

    typedef struct { int due; int esad; int eidx; int ernd; bit edn; } exp_t;

    vec_t vt[12];
    exp_t q[$];

    sad_best_select #(.DATAWIDTH(8), .NUM_ROUNDS(2)) dut (
        .clock(clock), .reset(reset), .start(start), .sad_valid(sad_valid),
        .left_only(left_only),
        .sad_0(sad[0]), .sad_1(sad[1]), .sad_2(sad[2]),  .sad_3(sad[3]),
        .sad_4(sad[4]), .sad_5(sad[5]), .sad_6(sad[6]),  .sad_7(sad[7]),
        .sad_8(sad[8]), .sad_9(sad[9]), .sad_10(sad[10]), .sad_11(sad[11]),
        .best_sad(best_sad), .best_idx(best_idx), .best_round(best_round),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one sample for one edge; optionally record its expected outcome at edge+3.
    task automatic drive_sample(input vec_t v, input bit with_start, input bit push);
        int s;
        exp_t e;
        for (int k = 0; k < 12; k++) begin
            s = v.base + v.step * k;
            if (k == v.k1) s = v.v1;
            if (k == v.k2) s = v.v2;
            sad[k] = SW'(s);
        end
        left_only = v.lo;
        sad_valid = 1'b1;
        start     = with_start;
        if (push) begin
            e.due = cyc + 4; e.esad = v.esad; e.eidx = v.eidx;
            e.ernd = v.ernd; e.edn = v.edn;
            q.push_back(e);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    // Scoreboard monitor: compare on due cycles, otherwise done must stay low.
    always @(negedge clock) begin : mon
        exp_t e;
        if (mon_en) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("best_sad", int'(best_sad), e.esad);
                chk("best_idx", int'(best_idx), e.eidx);
                chk("best_round", int'(best_round), e.ernd);
                chk("done", int'(done), int'(e.edn));
                chk("busy", int'(busy), int'(!e.edn));
            end else begin
                chk("done_idle", int'(done), 0);
            end
        end
    end

    initial begin
        vec_t a;
        // lo base step k1 v1 k2 v2 | esad eidx ernd edn (cumulative best after this sample)
        vt[0]  = '{1'b0, 100,   1,  7, 20, -1, 0,      20,  7, 0, 1'b0};
        vt[1]  = '{1'b0, 100,   1,  3, 15, -1, 0,      15,  3, 1, 1'b1};
        vt[2]  = '{1'b1, 50,    0,  9,  1, -1, 0,      50,  0, 0, 1'b0};
        vt[3]  = '{1'b0, 100,   0,  2, 30,  5, 30,     30,  2, 1, 1'b1};
        vt[4]  = '{1'b0, 90,    0,  4, 40, -1, 0,      40,  4, 0, 1'b0};
        vt[5]  = '{1'b0, 90,    0,  1, 40, -1, 0,      40,  4, 0, 1'b1};
        vt[6]  = '{1'b0, 1000, -10, -1, 0, -1, 0,      890, 11, 0, 1'b0};
        vt[7]  = '{1'b1, 1000, -10, -1, 0, -1, 0,      890, 11, 0, 1'b1};
        vt[8]  = '{1'b0, CMAX,  0, -1, 0, -1, 0,       CMAX, 0, 0, 1'b0};
        vt[9]  = '{1'b0, CMAX,  0, 11, CMAX-1, -1, 0,  CMAX-1, 11, 1, 1'b1};
        vt[10] = '{1'b1, 500,   0,  6, 0, -1, 0,       500, 0, 0, 1'b0};
        vt[11] = '{1'b0, 500,   0, 10, 0, 11, 0,       0,  10, 1, 1'b1};

        reset = 1'b1; start = 1'b0; sad_valid = 1'b0; left_only = 1'b0;
        for (int k = 0; k < 12; k++) sad[k] = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_best_sad", int'(best_sad), CMAX);
        chk("rst_best_idx", int'(best_idx), 0);
        chk("rst_best_round", int'(best_round), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        // sad_valid while idle without start is ignored
        sad_valid = 1'b1; tick(); sad_valid = 1'b0;
        tick(); tick(); tick();
        chk("idle_ignore_busy", int'(busy), 0);
        chk("idle_ignore_done", int'(done), 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("start_busy", int'(busy), 1);
        mon_en = 1'b1;

        // Table searches: start alone or with sample 0; samples back-to-back or gapped.
        for (int p = 0; p < 6; p++) begin
            if (p % 3 == 1) begin
                drive_sample(vt[2*p], 1'b1, 1'b1);
            end else begin
                start = 1'b1; sad_valid = 1'b0; tick(); start = 1'b0;
                drive_sample(vt[2*p], 1'b0, 1'b1);
            end
            if (p % 2 == 1) begin
                sad_valid = 1'b0; tick(); tick();
            end
            drive_sample(vt[2*p+1], 1'b0, 1'b1);
            // a third sample after NUM_ROUNDS must be ignored
            if (p == 2) drive_sample(vt[0], 1'b0, 1'b0);
            sad_valid = 1'b0;
            drain();
            tick();
            chk("hold_best_sad", int'(best_sad), vt[2*p+1].esad);
        end

        // Abort: sample sits in S2 when start arrives; it must never land and no done.
        a = '{1'b0, 100, 0, 0, 5, -1, 0, 0, 0, 0, 1'b0};
        drive_sample(a, 1'b1, 1'b0);
        sad_valid = 1'b0; tick();
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick(); tick();
        chk("abort_best_sad", int'(best_sad), CMAX);
        chk("abort_busy", int'(busy), 1);
        drive_sample(vt[0], 1'b0, 1'b1);
        drive_sample(vt[1], 1'b0, 1'b1);
        sad_valid = 1'b0;
        drain();

        // Reset landing on the done edge wins over done.
        mon_en = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        drive_sample(vt[2], 1'b0, 1'b0);
        drive_sample(vt[3], 1'b0, 1'b0);
        sad_valid = 1'b0;
        tick(); tick();
        chk("pre_rst_best_sad", int'(best_sad), 50);
        chk("pre_rst_done", int'(done), 0);
        chk("pre_rst_busy", int'(busy), 1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("donerst_done", int'(done), 0);
        chk("donerst_best_sad", int'(best_sad), CMAX);
        chk("donerst_best_idx", int'(best_idx), 0);
        chk("donerst_best_round", int'(best_round), 0);
        chk("donerst_busy", int'(busy), 0);
        tick(); tick(); tick();
        chk("post_rst_done", int'(done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
